// File: rtl/blu_pkg.sv
// rtl/blu_pkg.sv - shared opcode and buffer-state constants for the bitwise logic unit
//
// Purpose: opcode encodings and the output buffer state encodings.
// The buffer states are the packed pair {main_v, skid_v}.
package blu_pkg;

    localparam int BLU_OP_W = 3;

    typedef logic [BLU_OP_W-1:0] blu_op_t;

    localparam blu_op_t OP_NOT_A  = 3'b000;
    localparam blu_op_t OP_AND    = 3'b001;
    localparam blu_op_t OP_OR     = 3'b010;
    localparam blu_op_t OP_XOR    = 3'b011;
    localparam blu_op_t OP_NAND   = 3'b100;
    localparam blu_op_t OP_NOR    = 3'b101;
    localparam blu_op_t OP_XNOR   = 3'b110;
    localparam blu_op_t OP_PASS_A = 3'b111;

    localparam logic [1:0] BUF_EMPTY = 2'b00;
    localparam logic [1:0] BUF_MAIN  = 2'b10;
    localparam logic [1:0] BUF_FULL  = 2'b11;

endpackage

// File: rtl/bitwise_logic_core.sv
// rtl/bitwise_logic_core.sv - combinational bitwise operation with zero and parity flags
//
// Purpose: computes res = op(a, b) on all WIDTH bits, plus flags.
// Ports:
//   a, b  : WIDTH-bit operands (b unused by NOT_A and PASS_A)
//   op    : operation select (blu_pkg opcodes)
//   res   : WIDTH-bit result
//   zero  : res == 0
//   par   : XOR-reduction of res
module bitwise_logic_core
    import blu_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [BLU_OP_W-1:0] op,
    output logic [WIDTH-1:0]    res,
    output logic                zero,
    output logic                par
);

    always_comb begin
        res = a;
        case (op)
            OP_NOT_A:  res = ~a;
            OP_AND:    res = a & b;
            OP_OR:     res = a | b;
            OP_XOR:    res = a ^ b;
            OP_NAND:   res = ~(a & b);
            OP_NOR:    res = ~(a | b);
            OP_XNOR:   res = ~(a ^ b);
            OP_PASS_A: res = a;
            default:   res = a;
        endcase
    end

    assign zero = (res == '0);
    assign par  = ^res;

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - pipelined bitwise logic unit with valid/ready and skid buffer
//
// Purpose: optional input register, combinational core, 2-entry output
// buffer (main + skid) and a registered in_ready.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid/in_ready               : operand handshake
//   in_a, in_b, in_op               : operands and opcode
//   out_valid/out_ready             : result handshake
//   out_res, out_zero, out_par      : result and its flags
module bitwise_logic_unit
    import blu_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter bit REG_IN = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [BLU_OP_W-1:0] in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_res,
    output logic                out_zero,
    output logic                out_par
);

    // Input stage (stays empty and unused when REG_IN == 0)
    logic                stage_v, stage_v_n, stage_load;
    logic [WIDTH-1:0]    stage_a, stage_b;
    logic [BLU_OP_W-1:0] stage_op;

    // Beat presented to the buffer
    logic                src_valid;
    logic [WIDTH-1:0]    src_a, src_b;
    logic [BLU_OP_W-1:0] src_op;

    logic [WIDTH-1:0]    c_res;
    logic                c_zero, c_par;

    // Output buffer; buf_rdy mirrors !skid_v but is held low during reset
    logic                main_v, skid_v, main_v_n, skid_v_n;
    logic [WIDTH-1:0]    main_res, skid_res;
    logic                main_zero, main_par, skid_zero, skid_par;
    logic                buf_rdy, in_rdy_q;
    logic                acc, pop, load_main, load_skid, skid_to_main;

    assign src_valid = REG_IN ? stage_v  : in_valid;
    assign src_a     = REG_IN ? stage_a  : in_a;
    assign src_b     = REG_IN ? stage_b  : in_b;
    assign src_op    = REG_IN ? stage_op : in_op;

    bitwise_logic_core #(.WIDTH(WIDTH)) u_core (
        .a    (src_a),
        .b    (src_b),
        .op   (src_op),
        .res  (c_res),
        .zero (c_zero),
        .par  (c_par)
    );

    assign acc = src_valid && buf_rdy;
    assign pop = main_v && out_ready;

    always_comb begin
        main_v_n     = main_v;
        skid_v_n     = skid_v;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case ({main_v, skid_v})
            BUF_EMPTY: begin
                if (acc) begin
                    main_v_n  = 1'b1;
                    load_main = 1'b1;
                end
            end
            BUF_MAIN: begin
                if (acc && pop) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    skid_v_n  = 1'b1;
                    load_skid = 1'b1;
                end else if (pop) begin
                    main_v_n  = 1'b0;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    skid_v_n     = 1'b0;
                    skid_to_main = 1'b1;
                end
            end
            default: begin
                // {0,1} is unreachable; recover to empty
                main_v_n = 1'b0;
                skid_v_n = 1'b0;
            end
        endcase

        // The stage holds its beat until the buffer takes it
        stage_load = REG_IN && in_valid && in_rdy_q;
        stage_v_n  = REG_IN && (stage_load || (stage_v && !buf_rdy));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            buf_rdy   <= 1'b0;
            in_rdy_q  <= 1'b0;
            main_res  <= '0;
            main_zero <= 1'b0;
            main_par  <= 1'b0;
            skid_res  <= '0;
            skid_zero <= 1'b0;
            skid_par  <= 1'b0;
            stage_v   <= 1'b0;
            stage_a   <= '0;
            stage_b   <= '0;
            stage_op  <= '0;
        end else begin
            main_v   <= main_v_n;
            skid_v   <= skid_v_n;
            buf_rdy  <= !skid_v_n;
            // With an input stage, a slot is free unless both stage and skid are occupied
            in_rdy_q <= REG_IN ? !(stage_v_n && skid_v_n) : !skid_v_n;
            stage_v  <= stage_v_n;
            if (load_main) begin
                main_res  <= c_res;
                main_zero <= c_zero;
                main_par  <= c_par;
            end else if (skid_to_main) begin
                main_res  <= skid_res;
                main_zero <= skid_zero;
                main_par  <= skid_par;
            end
            if (load_skid) begin
                skid_res  <= c_res;
                skid_zero <= c_zero;
                skid_par  <= c_par;
            end
            if (stage_load) begin
                stage_a  <= in_a;
                stage_b  <= in_b;
                stage_op <= in_op;
            end
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = main_v;
    assign out_res   = main_res;
    assign out_zero  = main_zero;
    assign out_par   = main_par;

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Parametrised, pipelined successor to the fixed 10-bit bitwise inverter.
- Applies one of eight bitwise operations to two WIDTH-bit operands.
- Registers the result together with zero and parity flags.
- Uses a valid/ready handshake with a 2-entry output buffer (main + skid), so it can sit in a back-pressured datapath between the operand source and the ALU result mux.

Parameters:
- WIDTH, 10: operand/result width in bits, minimum 1.
- REG_IN, 0: 1 inserts an input register stage, adding 1 cycle of latency; 0 means no input register.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B; ignored by NOT_A and PASS_A
- in_op  in  3  operation select
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out_res  out  WIDTH  result
- out_zero  out  1  out_res == 0
- out_par  out  1  XOR-reduction of out_res (odd parity)

Behaviour:
- Opcodes: 000 NOT_A (~a), 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 PASS_A.
- Operations are pure bitwise on all WIDTH bits; no carries, no width extension.
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- in_valid, in_a, in_b and in_op must stay stable while in_valid=1 and in_ready=0. A bench assertion checks this; the RTL does not depend on it.
- Reset (rst_n=0, asynchronous): out_valid=0, out_res=0, out_zero=0, out_par=0, in_ready=0, skid empty, input stage (if present) empty.
- First cycle after reset deasserts: in_ready=1, and in_ready is registered from then on.
- Buffer state machine on {main_v, skid_v}:
  - EMPTY {0,0}: in_ready=1. Accept -> MAIN with the computed result.
  - MAIN {1,0}: in_ready=1.
    - Accept and out_ready -> MAIN; main is replaced with the new result.
    - Accept and !out_ready -> FULL; new result goes into skid.
    - No accept and out_ready -> EMPTY.
    - Otherwise hold.
  - FULL {1,1}: in_ready=0.
    - out_ready -> MAIN; skid moves into main.
    - Otherwise hold.
- State is never {0,1}.
- in_ready for the next cycle = !(next skid_v). It is a register, with no combinational path from out_ready.
- Latency:
  - REG_IN=0: result visible on out_* the cycle after acceptance (1 cycle).
  - REG_IN=1: 2 cycles. The input stage advances only when it is empty or its beat is consumed by the buffer, so throughput is still 1 beat/cycle.
- out_zero and out_par are computed with the result and stored alongside it; they never lag out_res.
- Full throughput: with in_valid=1 and out_ready=1 continuously, one result per cycle and no bubbles after the first.
- out_valid and the out_* data stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation drops every buffered beat; no partial output.
- WIDTH=1: all ops degrade to single-bit gates; out_par=out_res and out_zero=~out_res.

Decomposition:
- Shared package blu_pkg:
  - 3-bit opcode localparams OP_NOT_A..OP_PASS_A.
  - Localparam BLU_OP_W=3.
- One combinational sub-module, bitwise_logic_core (WIDTH param): a, b, op -> res, zero, par. The wrapper owns all state: input stage, main/skid buffer, in_ready register.

Test Plan:
- Reset then single beat (WIDTH=10, REG_IN=0): in_a=10'h2A5, op=NOT_A, out_ready=1 -> next cycle out_valid=1, out_res=10'h15A, out_zero=0, out_par=1; following cycle out_valid=0.
- Opcode sweep: a=10'h3F0, b=10'h0FF, ops 000..111 back-to-back with out_ready=1 -> res 10'h00F, 0F0, 3FF, 30F, 30F, 000, 0F0, 3F0 on consecutive cycles. The NOR result (000) gives zero=1.
- Back-pressure: out_ready=0, drive 3 beats -> first two accepted, in_ready=0 after the 2nd, 3rd held. Raise out_ready -> results emerge in order, nothing lost or duplicated, 3rd accepted the cycle after in_ready returns to 1.
- Streaming: 64 random beats, in_valid=1, random out_ready at 50% -> output sequence matches a reference model exactly; out_* stable whenever stalled.
- Async reset mid-FULL: assert rst_n=0 between clock edges -> out_valid=0 and in_ready=0 immediately. After release, first accepted beat is the first output.
- REG_IN=1, WIDTH=1: a=1, b=1, op=XNOR -> result 2 cycles after accept, res=1, par=1, zero=0; continuous stream still 1 beat/cycle.
